// File: rtl/freq_meter_auto.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : freq_meter_auto
// Description : Gated edge counter with N-digit BCD display, overflow flag and
//               auto-ranging gate. Optional macro LEADING_ZERO_BLANK_EN blanks
//               leading zero digits.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module freq_meter_auto #(
    parameter int DIGITS      = 4,
    parameter int CLK_HZ      = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  sigin,
    input  logic [1:0]            select,
    output logic [7*DIGITS-1:0]   seg,
    output logic [1:0]            range_out,
    output logic                  ovf,
    output logic                  valid
);

    localparam int              c_GW       = $clog2(CLK_HZ);
    localparam logic [c_GW-1:0] c_G0_LAST  = c_GW'(CLK_HZ - 1);
    localparam logic [c_GW-1:0] c_G1_LAST  = c_GW'(CLK_HZ / 10 - 1);
    localparam logic [c_GW-1:0] c_G2_LAST  = c_GW'(CLK_HZ / 100 - 1);
    localparam logic [1:0]      c_SEL_AUTO = 2'b11;

    localparam logic [0:0] c_ST_GATE  = 1'b0;
    localparam logic [0:0] c_ST_LATCH = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_edge;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [c_GW-1:0]        r_gate_cnt;
    logic [c_GW-1:0]        w_gate_last;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [4*DIGITS-1:0]    w_bcd_inc;
    logic [4*DIGITS-1:0]    r_disp;
    logic [DIGITS-1:0]      w_is9;
    logic [DIGITS-1:0]      w_carry;
    logic                   w_all9;
    logic                   r_ovf_flag;
    logic [1:0]             r_range;
    logic [1:0]             r_sel_q;
    logic                   w_sel_chg;
    logic                   w_gate_run;
    logic                   w_latch;
    logic                   w_abort;
    logic [3:0]             w_msd;

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'h3F;
            4'd1:    f_seg7 = 7'h06;
            4'd2:    f_seg7 = 7'h5B;
            4'd3:    f_seg7 = 7'h4F;
            4'd4:    f_seg7 = 7'h66;
            4'd5:    f_seg7 = 7'h6D;
            4'd6:    f_seg7 = 7'h7D;
            4'd7:    f_seg7 = 7'h07;
            4'd8:    f_seg7 = 7'h7F;
            4'd9:    f_seg7 = 7'h6F;
            default: f_seg7 = 7'h00;
        endcase
    endfunction

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sigin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_sel_chg = (select != r_sel_q);
    assign w_msd     = r_bcd[4*DIGITS-1 -: 4];

    always_comb begin
        case (r_range)
            2'd0:    w_gate_last = c_G0_LAST;
            2'd1:    w_gate_last = c_G1_LAST;
            default: w_gate_last = c_G2_LAST;
        endcase
    end

    // Ripple BCD increment; the all-nines case is handled by saturation below.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            logic [3:0] w_d;
            assign w_d      = r_bcd[4*k +: 4];
            assign w_is9[k] = (w_d == 4'd9);
            if (k == 0) begin : g_lsd
                assign w_carry[k] = 1'b1;
            end else begin : g_upper
                assign w_carry[k] = w_carry[k-1] & w_is9[k-1];
            end
            assign w_bcd_inc[4*k +: 4] = !w_carry[k] ? w_d :
                                         (w_is9[k] ? 4'd0 : 4'(w_d + 4'd1));
        end
    endgenerate

    assign w_all9 = &w_is9;

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) r_state <= c_ST_GATE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_GATE:  if (!w_sel_chg && (r_gate_cnt == w_gate_last)) w_state_nxt = c_ST_LATCH;
            c_ST_LATCH: w_state_nxt = c_ST_GATE;
            default:    w_state_nxt = c_ST_GATE;
        endcase
    end

    always_comb begin
        w_gate_run = 1'b0;
        w_latch    = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            c_ST_GATE: begin
                w_abort    = w_sel_chg;
                w_gate_run = ~w_sel_chg;
            end
            c_ST_LATCH: w_latch = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_gate_cnt <= '0;
            r_bcd      <= '0;
            r_ovf_flag <= 1'b0;
            r_disp     <= '0;
            r_range    <= 2'd0;
            r_sel_q    <= 2'd0;
            range_out  <= 2'd0;
            ovf        <= 1'b0;
            valid      <= 1'b0;
        end else begin
            r_sel_q <= select;
            valid   <= w_latch;
            if (w_abort || w_latch) begin
                r_gate_cnt <= '0;
                r_bcd      <= '0;
                r_ovf_flag <= 1'b0;
            end else if (w_gate_run) begin
                r_gate_cnt <= c_GW'(r_gate_cnt + 1'b1);
                if (w_edge) begin
                    if (w_all9) r_ovf_flag <= 1'b1;
                    else        r_bcd      <= w_bcd_inc;
                end
            end
            if (w_latch) begin
                r_disp    <= r_bcd;
                ovf       <= r_ovf_flag;
                range_out <= r_range;
            end
            // Range decision uses the value being latched this cycle.
            if ((w_abort || w_latch) && w_sel_chg && (select != c_SEL_AUTO)) begin
                r_range <= select;
            end else if (w_latch && (select == c_SEL_AUTO)) begin
                if (r_ovf_flag && (r_range < 2'd2))
                    r_range <= r_range + 2'd1;
                else if (!r_ovf_flag && (w_msd == 4'd0) && (r_range != 2'd0))
                    r_range <= r_range - 2'd1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS:1] w_lz;
    assign w_lz[DIGITS] = 1'b1;
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_seg
            logic [3:0] w_d;
            assign w_d = r_disp[4*k +: 4];
            if (k == 0) begin : g_lsd
                assign seg[6:0] = f_seg7(w_d);
            end else begin : g_upper
                assign w_lz[k]          = (w_d == 4'd0) & w_lz[k+1];
                assign seg[7*k +: 7]    = w_lz[k] ? 7'h00 : f_seg7(w_d);
            end
        end
    endgenerate
`else
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_seg
            assign seg[7*k +: 7] = f_seg7(r_disp[4*k +: 4]);
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_freq_meter_auto.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_freq_meter_auto
// Description : Directed bench for freq_meter_auto: reset, fixed gate,
//               overflow, auto-range up/down and mid-gate select change.
// Revision    : 1.0 - initial
// ============================================================================
module tb_freq_meter_auto;

    localparam int         c_CLK_HZ = 1000;
    localparam logic [6:0] c_S0     = 7'h3F;
    localparam logic [6:0] c_S1     = 7'h06;
    localparam logic [6:0] c_S5     = 7'h6D;
    localparam logic [6:0] c_S9     = 7'h6F;

    logic        sysclk  = 1'b0;
    logic        rst     = 1'b0;
    logic        sigin4  = 1'b0;
    logic        sigin2  = 1'b0;
    logic [1:0]  select4 = 2'b00;
    logic [1:0]  select2 = 2'b00;
    logic [27:0] seg4;
    logic [13:0] seg2;
    logic [1:0]  range4, range2;
    logic        ovf4, ovf2, valid4, valid2;

    int errors = 0;
    int checks = 0;
    int per4   = 20;
    int per2   = 10;
    int ph4    = 0;
    int ph2    = 0;
    int n;

    freq_meter_auto #(.DIGITS(4), .CLK_HZ(c_CLK_HZ), .SYNC_STAGES(2)) u_dut4 (
        .sysclk(sysclk), .rst(rst), .sigin(sigin4), .select(select4),
        .seg(seg4), .range_out(range4), .ovf(ovf4), .valid(valid4)
    );

    freq_meter_auto #(.DIGITS(2), .CLK_HZ(c_CLK_HZ), .SYNC_STAGES(2)) u_dut2 (
        .sysclk(sysclk), .rst(rst), .sigin(sigin2), .select(select2),
        .seg(seg2), .range_out(range2), .ovf(ovf2), .valid(valid2)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        ph4    = (ph4 + 1 >= per4) ? 0 : ph4 + 1;
        sigin4 = (ph4 < per4 / 2);
    end

    always @(negedge sysclk) begin
        ph2    = (ph2 + 1 >= per2) ? 0 : ph2 + 1;
        sigin2 = (ph2 < per2 / 2);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts rising sysclk edges until the chosen instance shows valid.
    task automatic wait_valid(input int which, input int lim, output int cnt);
        logic v;
        cnt = 0;
        v   = 1'b0;
        while (!v && cnt < lim) begin
            @(posedge sysclk);
            #1;
            cnt++;
            v = (which == 4) ? valid4 : valid2;
        end
        chk($sformatf("valid_seen_%0d", which), {31'd0, v}, 32'd1);
    endtask

    // Release reset with both inputs in their low half-period.
    task automatic release_rst();
        @(negedge sysclk);
        ph4 = per4 / 2;
        ph2 = per2 / 2;
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge sysclk);
        #1;
        chk("rst0_seg4",  seg4,   {c_S0, c_S0, c_S0, c_S0});
        chk("rst0_seg2",  seg2,   {c_S0, c_S0});
        chk("rst0_valid", valid4, 0);

        release_rst();
        wait_valid(4, 1200, n);
        chk("first_valid_lat", n, 1001);
        chk("sync_valid2", valid2, 1);
        chk("fix_seg4",  seg4,   {c_S0, c_S0, c_S5, c_S0});
        chk("fix_ovf4",  ovf4,   0);
        chk("fix_rng4",  range4, 0);
        chk("ovf_seg2",  seg2,   {c_S9, c_S9});
        chk("ovf_flag2", ovf2,   1);
        chk("ovf_rng2",  range2, 0);
        @(posedge sysclk);
        #1;
        chk("valid_one_cycle", valid4, 0);

        // Asynchronous reset mid-gate while sigin keeps toggling.
        repeat (300) @(posedge sysclk);
        @(negedge sysclk);
        #2 rst = 1'b0;
        #1;
        chk("rst_seg4",  seg4,   {c_S0, c_S0, c_S0, c_S0});
        chk("rst_rng4",  range4, 0);
        chk("rst_ovf4",  ovf4,   0);
        chk("rst_valid", valid4, 0);
        chk("rst_seg2",  seg2,   {c_S0, c_S0});
        chk("rst_ovf2",  ovf2,   0);
        repeat (2) @(negedge sysclk);
        release_rst();
        wait_valid(4, 1200, n);
        chk("rst_valid_lat", n, 1001);
        chk("rst_fix_seg4", seg4, {c_S0, c_S0, c_S5, c_S0});
        chk("rst_ovf_seg2", seg2, {c_S9, c_S9});
        chk("rst_ovf2b",    ovf2, 1);

        wait_valid(4, 1200, n);
        chk("fix_period", n, 1001);
        chk("fix_seg4b",  seg4, {c_S0, c_S0, c_S5, c_S0});

        // Select 00 -> 01 at gate cycle 500: gate aborted, display held.
        repeat (500) @(posedge sysclk);
        @(negedge sysclk);
        select4 = 2'b01;
        @(posedge sysclk);
        #1;
        chk("abort_valid", valid4, 0);
        chk("abort_hold",  seg4,   {c_S0, c_S0, c_S5, c_S0});
        chk("abort_rng",   range4, 0);
        wait_valid(4, 200, n);
        chk("sel_chg_lat", n, 101);
        chk("g1_seg4",  seg4,   {c_S0, c_S0, c_S0, c_S5});
        chk("g1_rng4",  range4, 1);
        chk("g1_ovf4",  ovf4,   0);
        wait_valid(4, 200, n);
        chk("g1_period", n, 101);

        // Auto-range on the 2-digit instance, switched right after a latch.
        wait_valid(2, 1200, n);
        @(negedge sysclk);
        select2 = 2'b11;
        @(posedge sysclk);
        #1;
        wait_valid(2, 1200, n);
        chk("auto_g0_lat", n, 1001);
        chk("auto_up_seg", seg2,   {c_S9, c_S9});
        chk("auto_up_ovf", ovf2,   1);
        chk("auto_up_rng", range2, 0);
        wait_valid(2, 200, n);
        chk("auto_g1_lat", n, 101);
        chk("auto_g1_seg", seg2,   {c_S1, c_S0});
        chk("auto_g1_ovf", ovf2,   0);
        chk("auto_g1_rng", range2, 1);
        wait_valid(2, 200, n);
        chk("auto_g1_seg2", seg2,   {c_S1, c_S0});
        chk("auto_g1_rng2", range2, 1);

        @(negedge sysclk);
        per2 = 200;
        for (int i = 0; i < 4; i++) begin
            wait_valid(2, 1200, n);
            if (range2 == 2'd0) break;
        end
        chk("auto_dn_rng", range2, 0);
        chk("auto_dn_seg", seg2,   {c_S0, c_S5});
        chk("auto_dn_ovf", ovf2,   0);
        wait_valid(2, 1200, n);
        chk("auto_dn_lat",  n,      1001);
        chk("auto_dn_seg2", seg2,   {c_S0, c_S5});
        chk("auto_dn_rng2", range2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
